frame_sequencer: RTL

Parametrised frame-run controller that drives the pseudo-sensor `start` line and counts down-scaled output pixels per frame. It sits between the test stimulus and the `pseudo_sensor` → `down_scale_controller` → `down_scale_PU` chain, closing the loop on `down_scale_valid`. It generalises the fixed 1024-pixel / 100-cycle-gap restart loop with:
- configurable frame size and gap,
- single, N-frame burst and continuous modes,
- abort,
- frame/sequence status pulses,
- an optional stall watchdog.

---
 rtl/frame_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame-run controller: drives the sensor start line and counts output pixels.
// Optional stall watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer #(
  parameter int PIX_PER_FRAME  = 1024,
  parameter int GAP_CYCLES     = 100,
  parameter int FRAME_CNT_W    = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  input  logic                             abort,
  input  logic [1:0]                       mode,
  input  logic [FRAME_CNT_W-1:0]           num_frames,
  input  logic                             pix_valid,
  output logic                             start,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             seq_done,
  output logic [FRAME_CNT_W-1:0]           frame_idx,
  output logic [$clog2(PIX_PER_FRAME)-1:0] pix_cnt,
  output logic                             timeout
);

  localparam int PW = $clog2(PIX_PER_FRAME);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PIX_ONE  = PW'(1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [FRAME_CNT_W-1:0] IDX_ONE = FRAME_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   fd_q;
  logic                   sd_q;
  logic [FRAME_CNT_W-1:0] frame_idx_q;
  logic [PW-1:0]          pix_cnt_q;
  logic [GW-1:0]          gap_cnt_q;
  logic [1:0]             mode_q;
  logic [FRAME_CNT_W-1:0] nf_q;

  logic [FRAME_CNT_W-1:0] idx_inc;
  logic [FRAME_CNT_W-1:0] nf_eff;
  logic                   last;

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_ONE  = WW'(1);
  logic [WW-1:0] wd_cnt_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign idx_inc = frame_idx_q + IDX_ONE;
  assign nf_eff  = (nf_q == '0) ? IDX_ONE : nf_q;

  // Burst ends on the programmed count; continuous only ends when run drops.
  always_comb begin
    last = !run;
    unique case (mode_q)
      2'd1:    last = last || (idx_inc == nf_eff);
      2'd2:    last = last;
      default: last = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
      sd_q        <= 1'b0;
      frame_idx_q <= '0;
      pix_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= '0;
      nf_q        <= '0;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      fd_q <= 1'b0;
      sd_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        start_q   <= 1'b0;
        busy_q    <= 1'b0;
        pix_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (run) begin
              state_q     <= RUN;
              start_q     <= 1'b1;
              busy_q      <= 1'b1;
              frame_idx_q <= '0;
              pix_cnt_q   <= '0;
              mode_q      <= mode;
              nf_q        <= num_frames;
`ifdef FRAME_SEQ_WATCHDOG_EN
              wd_cnt_q    <= '0;
              timeout_q   <= 1'b0;
`endif
            end
          end
          RUN: begin
`ifdef FRAME_SEQ_WATCHDOG_EN
            if (!pix_valid && wd_cnt_q == WD_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= IDLE;
              start_q   <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              wd_cnt_q <= pix_valid ? '0 : wd_cnt_q + WD_ONE;
`endif
              if (pix_valid) begin
                if (pix_cnt_q == PIX_LAST) begin
                  fd_q        <= 1'b1;
                  pix_cnt_q   <= '0;
                  frame_idx_q <= idx_inc;
                  start_q     <= 1'b0;
                  gap_cnt_q   <= '0;
                  if (last) begin
                    sd_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                  end else begin
                    state_q <= GAP;
                  end
                end else begin
                  pix_cnt_q <= pix_cnt_q + PIX_ONE;
                end
              end
`ifdef FRAME_SEQ_WATCHDOG_EN
            end
`endif
          end
          GAP: begin
            if (!run) begin
              sd_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (gap_cnt_q == GAP_LAST) begin
              state_q <= RUN;
              start_q <= 1'b1;
`ifdef FRAME_SEQ_WATCHDOG_EN
              wd_cnt_q <= '0;
`endif
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign start      = start_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign seq_done   = sd_q;
  assign frame_idx  = frame_idx_q;
  assign pix_cnt    = pix_cnt_q;

endmodule
